if_fetch_queue: RTL

Parametrised instruction-fetch stage with a decoupling prefetch queue. It generates the PC, reads the combinational instruction memory, and buffers up to QDEPTH {pc, instruction} pairs. Decode drains the queue through a valid/ready handshake. A single-cycle redirect from execute flushes the queue and restarts fetch at the jump target. The block sits between the instruction memory and the IF/ID boundary, replacing the unbuffered fetch stage.

---
 rtl/if_pkg.sv | 18 +
 rtl/if_sync_fifo.sv | 61 ++++++
 rtl/if_fetch_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types, constants and helpers for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned PC_SIZE        = 32;
  localparam int unsigned INST_WIDTH     = 32;
  localparam int unsigned DEFAULT_PC_INC = 1;

  typedef struct packed {
    logic [PC_SIZE-1:0]    pc;
    logic [INST_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Occupancy counters need one extra bit so that "full" is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Generic single-clock FIFO with synchronous flush; DEPTH must be a power of two.
module if_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                push,
  input  logic                                pop,
  input  logic [WIDTH-1:0]                    wdata,
  output logic [WIDTH-1:0]                    rdata,
  output logic [if_pkg::cnt_width(DEPTH)-1:0] count,
  output logic                                empty,
  output logic                                full
);
  import if_pkg::*;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  head_q;
  logic [PtrW-1:0]  tail_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      // A pop in the flush cycle is simply dropped along with everything else.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= wdata;
        tail_q        <= tail_q + PtrW'(1);
      end
      if (pop) begin
        head_q <= head_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign rdata = mem_q[head_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC generation plus a prefetch queue drained by decode.
// Optional perf counters are compiled in with IF_PERF_CNT_EN.
module if_fetch_queue #(
  parameter int unsigned       PC_SIZE    = 32,
  parameter int unsigned       INST_WIDTH = 32,
  parameter int unsigned       QDEPTH     = 4,
  parameter int unsigned       PC_INC     = if_pkg::DEFAULT_PC_INC,
  parameter logic [PC_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 redirect,
  input  logic [PC_SIZE-1:0]                   redirect_pc,
  output logic [PC_SIZE-1:0]                   imem_addr,
  output logic                                 imem_req,
  input  logic [INST_WIDTH-1:0]                imem_rdata,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PC_SIZE-1:0]                   out_pc,
  output logic [INST_WIDTH-1:0]                out_instr,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]                          perf_redirects,
  output logic [31:0]                          perf_full_stalls,
`endif
  output logic [if_pkg::cnt_width(QDEPTH)-1:0] q_count
);
  import if_pkg::*;

  localparam int unsigned EntryW = PC_SIZE + INST_WIDTH;

  logic [PC_SIZE-1:0] fetch_pc_q;
  logic [PC_SIZE-1:0] fetch_pc_d;
  logic [EntryW-1:0]  head_entry;
  logic               q_empty;
  logic               q_full;
  logic               pop;

  assign out_valid = !q_empty;
  assign pop       = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
  assign imem_req  = reset && !redirect && (!q_full || pop);
  assign imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + PC_SIZE'(PC_INC);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  if_sync_fifo #(
    .WIDTH(EntryW),
    .DEPTH(QDEPTH)
  ) u_queue (
    .clock(clock),
    .reset(reset),
    .flush(redirect),
    .push (imem_req),
    .pop  (pop),
    .wdata({fetch_pc_q, imem_rdata}),
    .rdata(head_entry),
    .count(q_count),
    .empty(q_empty),
    .full (q_full)
  );

  assign out_pc    = head_entry[EntryW-1:INST_WIDTH];
  assign out_instr = head_entry[INST_WIDTH-1:0];

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_redirects_q;
  logic [31:0] perf_full_stalls_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_redirects_q   <= '0;
      perf_full_stalls_q <= '0;
    end else begin
      if (redirect && (perf_redirects_q != '1)) begin
        perf_redirects_q <= perf_redirects_q + 32'd1;
      end
      if (q_full && !pop && (perf_full_stalls_q != '1)) begin
        perf_full_stalls_q <= perf_full_stalls_q + 32'd1;
      end
    end
  end

  assign perf_redirects   = perf_redirects_q;
  assign perf_full_stalls = perf_full_stalls_q;
`endif

endmodule
